// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types for the butterfly pipeline.
package ntt_pkg;

  localparam int unsigned NTT_WIDTH = 12;
  localparam int unsigned NTT_Q     = 3329;
  localparam int unsigned NTT_TAG_W = 8;

  typedef logic [NTT_WIDTH-1:0] coeff_t;
  typedef logic [NTT_TAG_W-1:0] tag_t;

  // -Q in two's complement, two bits wider than a coefficient so that the
  // sign of (raw_sum - Q) is unambiguous for any raw sum of two coefficients.
  localparam logic [NTT_WIDTH+1:0] NTT_Q_NEG = (NTT_WIDTH + 2)'(-NTT_Q);

endpackage

// File: rtl/prefix_adder.sv
// Kogge-Stone parallel-prefix adder with carry-in, purely combinational.
module prefix_adder #(
  parameter int unsigned W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Generate/propagate tree, then fold the carry-in into every group prefix.
  always_comb begin
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W-1:0] p0;
    logic [W-1:0] carry;
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    for (int k = 0; (1 << k) < int'(W); k++) begin
      gn = g;
      pn = p;
      for (int i = (1 << k); i < int'(W); i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
        pn[i] = p[i] & p[i - (1 << k)];
      end
      g = gn;
      p = pn;
    end
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < int'(W); i++) begin
      carry[i] = g[i-1] | (p[i-1] & cin);
    end
    sum = p0 ^ carry;
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor: (a+b) mod Q and (a-b) mod Q.
// S1 holds the raw sum/difference, S2 applies a single +-Q correction.
// Optional range flag enabled by defining MODADDSUB_RANGE_CHECK_EN.
module mod_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = NTT_WIDTH,
  parameter int unsigned Q     = NTT_Q,
  parameter int unsigned TAG_W = NTT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] diff_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  localparam logic [WIDTH+1:0] QNeg = (WIDTH + 2)'(-Q);
  localparam logic [WIDTH-1:0] QW   = WIDTH'(Q);

  logic             s1_valid_q;
  logic [WIDTH:0]   s_raw_q;
  logic [WIDTH:0]   d_raw_q;
  logic [TAG_W-1:0] tag1_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] diff_q;
  logic [TAG_W-1:0] tag2_q;

  logic             s1_en;
  logic             s2_en;
  logic [WIDTH:0]   s_add;
  logic [WIDTH:0]   d_add;
  logic [WIDTH+1:0] s_sub;
  logic [WIDTH-1:0] d_corr;
  logic             unused_bits;

  // Ready ripples combinationally back from out_ready; no skid buffer.
  always_comb begin
    s2_en    = !out_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en && !rst;
  end

  prefix_adder #(.W(WIDTH + 1)) u_s1_sum (
    .a  ({1'b0, a_i}),
    .b  ({1'b0, b_i}),
    .cin(1'b0),
    .sum(s_add)
  );

  // a + ~b + 1 = a - b; the MSB of the extended result is the borrow.
  prefix_adder #(.W(WIDTH + 1)) u_s1_diff (
    .a  ({1'b0, a_i}),
    .b  (~{1'b0, b_i}),
    .cin(1'b1),
    .sum(d_add)
  );

  // Stage 1: capture raw sum/difference and sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s_raw_q    <= '0;
      d_raw_q    <= '0;
      tag1_q     <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      s_raw_q    <= s_add;
      d_raw_q    <= d_add;
      tag1_q     <= tag_i;
    end
  end

  // s_raw - Q; a set MSB means s_raw < Q, so no correction.
  prefix_adder #(.W(WIDTH + 2)) u_s2_sum (
    .a  ({1'b0, s_raw_q}),
    .b  (QNeg),
    .cin(1'b0),
    .sum(s_sub)
  );

  prefix_adder #(.W(WIDTH)) u_s2_diff (
    .a  (d_raw_q[WIDTH-1:0]),
    .b  (d_raw_q[WIDTH] ? QW : '0),
    .cin(1'b0),
    .sum(d_corr)
  );

  assign unused_bits = s_sub[WIDTH];

  // Stage 2: corrected results; holds bit-stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      diff_q      <= '0;
      tag2_q      <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      sum_q       <= s_sub[WIDTH+1] ? s_raw_q[WIDTH-1:0] : s_sub[WIDTH-1:0];
      diff_q      <= d_corr;
      tag2_q      <= tag1_q;
    end
  end

`ifdef MODADDSUB_RANGE_CHECK_EN
  logic err1_q;
  logic err2_q;

  // Range flag travels with its beat through both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      if (s1_en) err1_q <= ({1'b0, a_i} >= {1'b0, QW}) || ({1'b0, b_i} >= {1'b0, QW});
      if (s2_en) err2_q <= err1_q;
    end
  end

  assign err_o = err2_q;
`else
  assign err_o = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign sum_o     = sum_q;
  assign diff_o    = diff_q;
  assign tag_o     = tag2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe (Q=3329, WIDTH=12).
module tb_mod_addsub_pipe;

  localparam int Q  = 3329;
  localparam int NR = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_i;
  logic [11:0] b_i;
  logic [7:0]  tag_i;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum_o;
  logic [11:0] diff_o;
  logic [7:0]  tag_o;
  logic        err_o;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int a;
    int b;
    int tag;
    int sum;
    int diff;
  } vec_t;

  typedef struct {
    int sum;
    int diff;
    int tag;
    int err;
  } exp_t;

  vec_t tbl[7];
  exp_t expq[$];

  always #5 clk = ~clk;

  mod_addsub_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_i      (a_i),
    .b_i      (b_i),
    .tag_i    (tag_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_o    (sum_o),
    .diff_o   (diff_o),
    .tag_o    (tag_o),
    .err_o    (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: one conditional correction, result kept to 12 bits.
  function automatic exp_t model(input int a, input int b, input int tag);
    exp_t e;
    int s;
    int d;
    s = a + b;
    d = a - b;
    e.sum  = ((s >= Q) ? s - Q : s) & 12'hfff;
    e.diff = ((d < 0) ? d + Q : d) & 12'hfff;
    e.tag  = tag & 8'hff;
`ifdef MODADDSUB_RANGE_CHECK_EN
    e.err  = (a >= Q || b >= Q) ? 1 : 0;
`else
    e.err  = 0;
`endif
    return e;
  endfunction

  function automatic int exp_err(input int a, input int b);
`ifdef MODADDSUB_RANGE_CHECK_EN
    return (a >= Q || b >= Q) ? 1 : 0;
`else
    return (a < 0 && b < 0) ? 1 : 0;
`endif
  endfunction

  // Single pair with an idle pipe: checks 2-cycle latency and results.
  task automatic send_check(input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_i       = 12'(v.a);
    b_i       = 12'(v.b);
    tag_i     = 8'(v.tag);
    #1;
    chk("accept in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency c+1 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency c+2 out_valid", 32'(out_valid), 1);
    chk("vec sum", 32'(sum_o), 32'(v.sum));
    chk("vec diff", 32'(diff_o), 32'(v.diff));
    chk("vec tag", 32'(tag_o), 32'(v.tag));
    chk("vec err", 32'(err_o), 32'(exp_err(v.a, v.b)));
  endtask

  initial begin
    vec_t bp[3];
    int   got;
    int   sent;
    int   recv;
    bit   acc;
    exp_t e;

    tbl[0] = '{a: 3000, b: 1000, tag: 8'h11, sum: 671,  diff: 2000};
    tbl[1] = '{a: 5,    b: 10,   tag: 8'h22, sum: 15,   diff: 3324};
    tbl[2] = '{a: 0,    b: 0,    tag: 8'h33, sum: 0,    diff: 0};
    tbl[3] = '{a: 3328, b: 3328, tag: 8'h44, sum: 3327, diff: 0};
    tbl[4] = '{a: 3328, b: 1,    tag: 8'h55, sum: 0,    diff: 3327};
    tbl[5] = '{a: 1,    b: 3328, tag: 8'h66, sum: 0,    diff: 2};
    tbl[6] = '{a: 4095, b: 0,    tag: 8'h77, sum: 766,  diff: 4095};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    tag_i     = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset sum", 32'(sum_o), 0);
    chk("reset diff", 32'(diff_o), 0);
    chk("reset tag", 32'(tag_o), 0);
    chk("reset err", 32'(err_o), 0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) send_check(tbl[i]);

    // Backpressure: three back-to-back pairs against a stalled sink.
    bp[0] = '{a: 100,  b: 200,  tag: 8'ha0, sum: 300,  diff: 3229};
    bp[1] = '{a: 2000, b: 2000, tag: 8'ha1, sum: 671,  diff: 0};
    bp[2] = '{a: 3300, b: 29,   tag: 8'ha2, sum: 0,    diff: 3271};
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_i      = 12'(bp[i].a);
      b_i      = 12'(bp[i].b);
      tag_i    = 8'(bp[i].tag);
      #1;
      chk("bp accept in_ready", 32'(in_ready), 1);
      @(negedge clk);
    end
    a_i   = 12'(bp[2].a);
    b_i   = 12'(bp[2].b);
    tag_i = 8'(bp[2].tag);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp in_ready low", 32'(in_ready), 0);
      chk("bp hold valid", 32'(out_valid), 1);
      chk("bp hold sum", 32'(sum_o), 32'(bp[0].sum));
      chk("bp hold tag", 32'(tag_o), 32'(bp[0].tag));
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    acc = 1'b0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      if (acc) in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp drain sum", 32'(sum_o), 32'(bp[got].sum));
        chk("bp drain diff", 32'(diff_o), 32'(bp[got].diff));
        chk("bp drain tag", 32'(tag_o), 32'(bp[got].tag));
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp drain count", 32'(got), 3);
    repeat (2) begin
      @(negedge clk);
      chk("bp no duplicate", 32'(out_valid), 0);
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_i      = 12'(10 + i);
      b_i      = 12'(20 + i);
      tag_i    = 8'(8'hc0 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full before reset", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid reset in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("after reset out_valid", 32'(out_valid), 0);
    chk("after reset in_ready", 32'(in_ready), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no stale output", 32'(out_valid), 0);
    end
    send_check(tbl[0]);

    // Randomized stream against the reference model.
    sent = 0;
    recv = 0;
    acc  = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 80000 && recv < NR; cyc++) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        if (sent < NR && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          if ($urandom_range(15) == 0) begin
            a_i = 12'($urandom_range(4095));
            b_i = 12'($urandom_range(4095));
          end else begin
            a_i = 12'($urandom_range(Q - 1));
            b_i = 12'($urandom_range(Q - 1));
          end
          tag_i = 8'(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        expq.push_back(model(int'(a_i), int'(b_i), int'(tag_i)));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stream unexpected beat: got tag %0d, expected none", tag_o);
        end else begin
          e = expq.pop_front();
          chk("stream sum", 32'(sum_o), 32'(e.sum));
          chk("stream diff", 32'(diff_o), 32'(e.diff));
          chk("stream tag", 32'(tag_o), 32'(e.tag));
          chk("stream err", 32'(err_o), 32'(e.err));
        end
        recv++;
      end
    end
    in_valid = 1'b0;
    chk("stream beats received", 32'(recv), NR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
